// File: rtl/alu_mc.sv
// Multi-cycle ALU: single-cycle logic/arithmetic ops plus an iterative shift-add multiplier.
// Results, flags and status are all registered and presented with a one-cycle out_valid pulse.
module alu_mc #(
    parameter int WIDTH  = 32,
    parameter bit MUL_EN = 1'b1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [WIDTH-1:0] imm,
    input  logic             set_flags,
    output logic             out_valid,
    output logic [WIDTH-1:0] result,
    output logic             res_wr,
    output logic             err,
    output logic [3:0]       flags
);

    localparam int CNT_W = $clog2(WIDTH + 1);

    localparam logic [3:0] OP_ADD  = 4'd0;
    localparam logic [3:0] OP_ADDI = 4'd1;
    localparam logic [3:0] OP_SUB  = 4'd2;
    localparam logic [3:0] OP_AND  = 4'd3;
    localparam logic [3:0] OP_ORR  = 4'd4;
    localparam logic [3:0] OP_EOR  = 4'd5;
    localparam logic [3:0] OP_MOV  = 4'd6;
    localparam logic [3:0] OP_MVN  = 4'd7;
    localparam logic [3:0] OP_CMP  = 4'd8;
    localparam logic [3:0] OP_TST  = 4'd9;
    localparam logic [3:0] OP_TEQ  = 4'd10;
    localparam logic [3:0] OP_BIC  = 4'd11;
    localparam logic [3:0] OP_MUL  = 4'd12;

    typedef enum logic {
        IDLE,
        MUL_BUSY
    } state_t;

    state_t           state;
    logic [CNT_W-1:0] count;
    logic [WIDTH-1:0] mcand;
    logic [WIDTH-1:0] mplier;
    logic [WIDTH-1:0] acc;
    logic [WIDTH-1:0] mul_next;
    logic             mul_sf;

    logic [WIDTH-1:0] addend;
    logic [WIDTH:0]   sum_ext;
    logic [WIDTH:0]   diff_ext;
    logic [WIDTH-1:0] alu_res;
    logic             alu_c;
    logic             alu_v;
    logic             upd_cv;
    logic             force_flags;
    logic             alu_wr;
    logic             alu_illegal;
    logic             is_mul;

    assign in_ready = (state == IDLE) && !reset;
    assign mul_next = acc + (mplier[0] ? mcand : '0);

    // Decode the single-cycle datapath; the extra top bit of the sum/difference carries C.
    always_comb begin
        addend      = (op == OP_ADDI) ? imm : b;
        sum_ext     = {1'b0, a} + {1'b0, addend};
        diff_ext    = {1'b0, a} - {1'b0, b};
        alu_res     = '0;
        alu_c       = 1'b0;
        alu_v       = 1'b0;
        upd_cv      = 1'b0;
        force_flags = 1'b0;
        alu_wr      = 1'b1;
        alu_illegal = 1'b0;
        is_mul      = 1'b0;
        case (op)
            OP_ADD, OP_ADDI: begin
                alu_res = sum_ext[WIDTH-1:0];
                alu_c   = sum_ext[WIDTH];
                alu_v   = (a[WIDTH-1] == addend[WIDTH-1]) && (sum_ext[WIDTH-1] != a[WIDTH-1]);
                upd_cv  = 1'b1;
            end
            OP_SUB, OP_CMP: begin
                alu_res = diff_ext[WIDTH-1:0];
                alu_c   = ~diff_ext[WIDTH];
                alu_v   = (a[WIDTH-1] != b[WIDTH-1]) && (diff_ext[WIDTH-1] != a[WIDTH-1]);
                upd_cv  = 1'b1;
                if (op == OP_CMP) begin
                    force_flags = 1'b1;
                    alu_wr      = 1'b0;
                end
            end
            OP_AND: alu_res = a & b;
            OP_ORR: alu_res = a | b;
            OP_EOR: alu_res = a ^ b;
            OP_MOV: alu_res = b;
            OP_MVN: alu_res = ~b;
            OP_BIC: alu_res = a & ~b;
            OP_TST: begin
                alu_res     = a & b;
                force_flags = 1'b1;
                alu_wr      = 1'b0;
            end
            OP_TEQ: begin
                alu_res     = a ^ b;
                force_flags = 1'b1;
                alu_wr      = 1'b0;
            end
            OP_MUL: begin
                if (MUL_EN) begin
                    is_mul = 1'b1;
                end else begin
                    alu_illegal = 1'b1;
                    alu_wr      = 1'b0;
                end
            end
            default: begin
                alu_illegal = 1'b1;
                alu_wr      = 1'b0;
            end
        endcase
    end

    // Control FSM and all registered outputs; out_valid defaults low so it only ever pulses.
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            count     <= '0;
            result    <= '0;
            flags     <= 4'b0000;
            out_valid <= 1'b0;
            res_wr    <= 1'b0;
            err       <= 1'b0;
            mcand     <= '0;
            mplier    <= '0;
            acc       <= '0;
            mul_sf    <= 1'b0;
        end else begin
            out_valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        if (is_mul) begin
                            mcand  <= a;
                            mplier <= b;
                            acc    <= '0;
                            count  <= '0;
                            mul_sf <= set_flags;
                            state  <= MUL_BUSY;
                        end else begin
                            out_valid <= 1'b1;
                            result    <= alu_illegal ? '0 : alu_res;
                            res_wr    <= alu_wr;
                            err       <= alu_illegal;
                            if (!alu_illegal && (force_flags || set_flags)) begin
                                flags[3] <= alu_res[WIDTH-1];
                                flags[2] <= (alu_res == '0);
                                if (upd_cv) begin
                                    flags[1] <= alu_c;
                                    flags[0] <= alu_v;
                                end
                            end
                        end
                    end
                end
                MUL_BUSY: begin
                    acc    <= mul_next;
                    mcand  <= mcand << 1;
                    mplier <= mplier >> 1;
                    count  <= count + CNT_W'(1);
                    // The WIDTH-th partial product lands here, so finish without an extra cycle.
                    if (count == CNT_W'(WIDTH - 1)) begin
                        result    <= mul_next;
                        res_wr    <= 1'b1;
                        err       <= 1'b0;
                        out_valid <= 1'b1;
                        count     <= '0;
                        state     <= IDLE;
                        if (mul_sf) begin
                            flags[3] <= mul_next[WIDTH-1];
                            flags[2] <= (mul_next == '0);
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_mc.sv
// Self-checking bench for alu_mc (WIDTH = 32): directed vectors plus random ops
// compared against an arithmetic reference model of results and NZCV flags.
module tb_alu_mc;

    localparam int W = 32;

    logic         clk;
    logic         reset;
    logic         in_valid;
    logic         in_ready;
    logic [3:0]   op;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] imm;
    logic         set_flags;
    logic         out_valid;
    logic [W-1:0] result;
    logic         res_wr;
    logic         err;
    logic [3:0]   flags;

    int n_checks;
    int n_fail;

    logic [W-1:0] exp_res;
    logic         exp_wr;
    logic         exp_err;
    logic [3:0]   exp_flags;

    alu_mc #(.WIDTH(W), .MUL_EN(1'b1)) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .op        (op),
        .a         (a),
        .b         (b),
        .imm       (imm),
        .set_flags (set_flags),
        .out_valid (out_valid),
        .result    (result),
        .res_wr    (res_wr),
        .err       (err),
        .flags     (flags)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #3000000;
        $display("[TB] FAIL watchdog: observed timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        n_checks++;
        assert (observed === expected)
        else begin
            n_fail++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic [3:0] o, input logic [W-1:0] ia, input logic [W-1:0] ib,
                                 input logic [W-1:0] iimm, input logic sf);
        in_valid  = 1'b1;
        op        = o;
        a         = ia;
        b         = ib;
        imm       = iimm;
        set_flags = sf;
    endtask

    // Reference model: plain 64-bit arithmetic and signed range checks.
    task automatic model(input logic [3:0] o, input logic [W-1:0] ia, input logic [W-1:0] ib,
                         input logic [W-1:0] iimm, input logic sf);
        logic [63:0] wide;
        longint      sres;
        logic        arith, illegal, upd, c, v;
        arith   = 1'b0;
        illegal = 1'b0;
        c       = 1'b0;
        v       = 1'b0;
        sres    = 0;
        wide    = 64'd0;
        case (o)
            4'd0, 4'd1: begin
                logic [W-1:0] opnd;
                opnd = (o == 4'd1) ? iimm : ib;
                wide = {32'd0, ia} + {32'd0, opnd};
                sres = longint'($signed(ia)) + longint'($signed(opnd));
                c = wide[32];
                arith = 1'b1;
            end
            4'd2, 4'd8: begin
                wide = {32'd0, ia - ib};
                sres = longint'($signed(ia)) - longint'($signed(ib));
                c = (ia >= ib);
                arith = 1'b1;
            end
            4'd3, 4'd9:  wide = {32'd0, ia & ib};
            4'd4:        wide = {32'd0, ia | ib};
            4'd5, 4'd10: wide = {32'd0, ia ^ ib};
            4'd6:        wide = {32'd0, ib};
            4'd7:        wide = {32'd0, ~ib};
            4'd11:       wide = {32'd0, ia & ~ib};
            4'd12:       wide = {32'd0, ia} * {32'd0, ib};
            default:     illegal = 1'b1;
        endcase
        v = arith && (sres > longint'(32'h7FFFFFFF) || sres < -longint'(64'h80000000));
        exp_res = illegal ? '0 : wide[W-1:0];
        exp_err = illegal;
        exp_wr  = !illegal && !(o == 4'd8 || o == 4'd9 || o == 4'd10);
        upd     = (o == 4'd8 || o == 4'd9 || o == 4'd10) || sf;
        if (!illegal && upd) begin
            exp_flags[3] = exp_res[W-1];
            exp_flags[2] = (exp_res == '0);
            if (arith) exp_flags[1:0] = {c, v};
        end
    endtask

    // Issue one op, wait for its response (MUL waits its full latency) and check it.
    task automatic runOp(input string tag, input logic [3:0] o, input logic [W-1:0] ia,
                         input logic [W-1:0] ib, input logic [W-1:0] iimm, input logic sf,
                         input bit keep, input bit hold_busy);
        int busy_low;
        applyStimulus(o, ia, ib, iimm, sf);
        checkOutput({tag, ":in_ready"}, 64'(in_ready), 64'd1);
        model(o, ia, ib, iimm, sf);
        tick();
        if (o == 4'd12) begin
            if (hold_busy) applyStimulus(4'd0, 32'h1, 32'h1, 32'h0, 1'b1);
            else in_valid = 1'b0;
            busy_low = 0;
            for (int c = 0; c < W; c++) begin
                if (in_ready === 1'b0 && out_valid === 1'b0) busy_low++;
                tick();
            end
            checkOutput({tag, ":busy_cycles"}, 64'(busy_low), 64'(W));
            if (hold_busy) in_valid = 1'b0;
        end
        checkOutput({tag, ":out_valid"}, 64'(out_valid), 64'd1);
        checkOutput({tag, ":result"}, 64'(result), 64'(exp_res));
        checkOutput({tag, ":res_wr"}, 64'(res_wr), 64'(exp_wr));
        checkOutput({tag, ":err"}, 64'(err), 64'(exp_err));
        checkOutput({tag, ":flags"}, 64'(flags), 64'(exp_flags));
        if (!keep) in_valid = 1'b0;
    endtask

    initial begin
        int ov_count;
        logic [3:0] rop;
        n_checks  = 0;
        n_fail    = 0;
        exp_flags = 4'b0000;
        reset     = 1'b1;
        in_valid  = 1'b0;
        op        = 4'd0;
        a         = '0;
        b         = '0;
        imm       = '0;
        set_flags = 1'b0;

        tick();
        tick();
        checkOutput("reset:in_ready", 64'(in_ready), 64'd0);
        checkOutput("reset:out_valid", 64'(out_valid), 64'd0);
        checkOutput("reset:result", 64'(result), 64'd0);
        checkOutput("reset:flags", 64'(flags), 64'd0);
        checkOutput("reset:res_wr", 64'(res_wr), 64'd0);
        checkOutput("reset:err", 64'(err), 64'd0);
        reset = 1'b0;
        #1;
        checkOutput("release:in_ready", 64'(in_ready), 64'd1);

        runOp("add_ovf", 4'd0, 32'h7FFFFFFF, 32'h1, 32'h0, 1'b1, 1'b0, 1'b0);
        checkOutput("add_ovf:vec_result", 64'(result), 64'h80000000);
        checkOutput("add_ovf:vec_flags", 64'(flags), 64'b1001);
        tick();
        checkOutput("add_ovf:pulse_end", 64'(out_valid), 64'd0);
        checkOutput("add_ovf:result_hold", 64'(result), 64'h80000000);

        runOp("sub_zero", 4'd2, 32'h5, 32'h5, 32'h0, 1'b1, 1'b0, 1'b0);
        checkOutput("sub_zero:vec_flags", 64'(flags), 64'b0110);
        runOp("cmp", 4'd8, 32'h0, 32'h111, 32'h0, 1'b0, 1'b0, 1'b0);
        checkOutput("cmp:vec_result", 64'(result), 64'hFFFFFEEF);
        checkOutput("cmp:vec_flags", 64'(flags), 64'b1000);

        runOp("mul", 4'd12, 32'h0000FFFF, 32'h00010001, 32'h0, 1'b1, 1'b0, 1'b1);
        checkOutput("mul:vec_result", 64'(result), 64'hFFFFFFFF);
        checkOutput("mul:vec_flags", 64'(flags), 64'b1000);
        tick();
        checkOutput("mul:no_extra_accept", 64'(out_valid), 64'd0);

        // Abort a multiply part-way with reset.
        applyStimulus(4'd12, 32'h1234, 32'h5678, 32'h0, 1'b1);
        tick();
        in_valid = 1'b0;
        for (int i = 0; i < 9; i++) tick();
        reset = 1'b1;
        #1;
        checkOutput("mul_abort:in_ready_in_reset", 64'(in_ready), 64'd0);
        tick();
        checkOutput("mul_abort:out_valid", 64'(out_valid), 64'd0);
        checkOutput("mul_abort:flags", 64'(flags), 64'd0);
        checkOutput("mul_abort:result", 64'(result), 64'd0);
        reset = 1'b0;
        #1;
        checkOutput("mul_abort:in_ready", 64'(in_ready), 64'd1);
        exp_flags = 4'b0000;
        ov_count = 0;
        for (int i = 0; i < 40; i++) begin
            if (out_valid !== 1'b0) ov_count++;
            tick();
        end
        checkOutput("mul_abort:no_late_valid", 64'(ov_count), 64'd0);

        runOp("add_cv", 4'd0, 32'hFFFFFFFF, 32'h80000000, 32'h0, 1'b1, 1'b0, 1'b0);
        checkOutput("add_cv:vec_flags", 64'(flags), 64'b0011);
        runOp("add_nosf", 4'd0, 32'h7FFFFFFF, 32'h1, 32'h0, 1'b0, 1'b0, 1'b0);
        checkOutput("add_nosf:vec_flags", 64'(flags), 64'b0011);
        runOp("orr", 4'd4, 32'h00100100, 32'h01000111, 32'h0, 1'b1, 1'b0, 1'b0);
        checkOutput("orr:vec_result", 64'(result), 64'h01100111);
        checkOutput("orr:vec_flags", 64'(flags), 64'b0011);

        runOp("b2b_orr", 4'd4, 32'hF0F0F0F0, 32'h0F00000F, 32'h0, 1'b1, 1'b1, 1'b0);
        runOp("b2b_eor", 4'd5, 32'hFFFF0000, 32'hFFFF0000, 32'h0, 1'b1, 1'b1, 1'b0);
        runOp("b2b_bic", 4'd11, 32'hDEADBEEF, 32'h0000FFFF, 32'h0, 1'b1, 1'b1, 1'b0);
        runOp("illegal", 4'd14, 32'h1, 32'h2, 32'h0, 1'b1, 1'b0, 1'b0);
        checkOutput("illegal:vec_err", 64'(err), 64'd1);
        checkOutput("illegal:vec_res_wr", 64'(res_wr), 64'd0);

        runOp("addi", 4'd1, 32'hFFFFFFF0, 32'h0, 32'h10, 1'b1, 1'b0, 1'b0);
        runOp("mvn", 4'd7, 32'h0, 32'h0, 32'h0, 1'b1, 1'b0, 1'b0);
        runOp("tst", 4'd9, 32'hF0, 32'h0F, 32'h0, 1'b0, 1'b0, 1'b0);
        runOp("teq", 4'd10, 32'h80000000, 32'h1, 32'h0, 1'b0, 1'b0, 1'b0);
        runOp("mov", 4'd6, 32'h0, 32'h0, 32'h0, 1'b1, 1'b0, 1'b0);

        for (int i = 0; i < 60; i++) begin
            rop = 4'($urandom_range(0, 15));
            runOp("rand", rop, $urandom, $urandom, $urandom, 1'($urandom_range(0, 1)),
                  1'($urandom_range(0, 1)), 1'b0);
        end
        in_valid = 1'b0;
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
